axis_pkt_arb: RTL and testbench

Packet-granular round-robin arbiter that shares one AXI-Stream FIFO write port among PORTS upstream requesters. It grants one input for a whole packet (first beat through the tlast beat), forwards beats through a single registered output stage into the FIFO's slave side, and holds off starting new packets while the FIFO reports full. The block sits directly in front of the application-template stream FIFO, in that FIFO's write-clock domain.

---
 rtl/axis_arb_pkg.sv | 16 +
 rtl/rr_prio_enc.sv | 35 +++
 rtl/axis_pkt_arb.sv | 134 +++++++++++++
 tb/tb_axis_pkt_arb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared encodings and helpers for the AXI-Stream packet arbiter family.
package axis_arb_pkg;

  localparam int unsigned PORTS_MAX = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Width of an index into n requesters; a single requester still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Round-robin priority encoder: first request at or after last+1, scanning upward with wrap.
module rr_prio_enc
  import axis_arb_pkg::*;
#(
  parameter int unsigned PORTS = 4,
  localparam int unsigned IDX_W = idx_width(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [PORTS-1:0] winner,
  output logic [IDX_W-1:0] win_idx,
  output logic             valid
);

  // Scan PORTS candidates starting one past the previous winner; first hit wins.
  always_comb begin
    int unsigned p;
    logic [IDX_W-1:0] pi;
    winner  = '0;
    win_idx = '0;
    valid   = 1'b0;
    p       = 0;
    pi      = '0;
    for (int unsigned i = 1; i <= PORTS; i++) begin
      p  = (32'(last) + i) % PORTS;
      pi = IDX_W'(p);
      if (!valid && req[pi]) begin
        valid      = 1'b1;
        winner[pi] = 1'b1;
        win_idx    = pi;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_arb.sv
// Packet-granular round-robin arbiter feeding one AXI-Stream FIFO write port.
module axis_pkt_arb
  import axis_arb_pkg::*;
#(
  parameter int unsigned PORTS      = 4,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = (DATA_WIDTH + 7) / 8
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  output logic [PORTS-1:0]            s_axis_tready,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [PORTS-1:0]            s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
  output logic                        m_axis_tlast,
  input  logic                        fifo_full,
  output logic [PORTS-1:0]            grant,
  output logic [31:0]                 pkt_count
);

  localparam int unsigned IDX_W = idx_width(PORTS);

  arb_state_t       state_q, state_d;
  logic [PORTS-1:0] grant_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic [PORTS-1:0] arb_winner;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;

  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  sel_last;
  logic                  sel_valid;
  logic                  out_free;
  logic                  accept;

  rr_prio_enc #(.PORTS(PORTS)) u_rr (
    .req     (s_axis_tvalid),
    .last    (last_q),
    .winner  (arb_winner),
    .win_idx (arb_idx),
    .valid   (arb_valid)
  );

  // Output stage can take a beat when empty or draining this cycle.
  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = grant & {PORTS{out_free}};
  assign accept        = (state_q == ST_BUSY) && sel_valid && out_free;

  // Input mux steered by the granted index (last holds the current winner).
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (last_q == IDX_W'(i)) begin
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_last  = s_axis_tlast[i];
        sel_valid = s_axis_tvalid[i];
      end
    end
  end

  // State, grant and last-winner registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      grant   <= '0;
      last_q  <= IDX_W'(PORTS - 1);
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state: arbitrate in IDLE (only when the FIFO has room), hold grant until tlast is accepted.
  always_comb begin
    state_d = state_q;
    grant_d = grant;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid && !fifo_full) begin
          state_d = ST_BUSY;
          grant_d = arb_winner;
          last_d  = arb_idx;
        end
      end
      ST_BUSY: begin
        if (accept && sel_last) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single output register: load on accept, hold under backpressure, clear valid when drained.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_data;
      m_axis_tkeep  <= sel_keep;
      m_axis_tlast  <= sel_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Count packets leaving on m_axis; wraps naturally at 2^32.
  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_count <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_axis_pkt_arb.sv
// Directed bench for axis_pkt_arb: cycle table plus hand-written multi-cycle sequences.
module tb_axis_pkt_arb;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned KW = 4;

  logic               aclk;
  logic               areset;
  logic [NP-1:0]      s_axis_tvalid;
  logic [NP-1:0]      s_axis_tready;
  logic [NP*DW-1:0]   s_axis_tdata;
  logic [NP*KW-1:0]   s_axis_tkeep;
  logic [NP-1:0]      s_axis_tlast;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic [DW-1:0]      m_axis_tdata;
  logic [KW-1:0]      m_axis_tkeep;
  logic               m_axis_tlast;
  logic               fifo_full;
  logic [NP-1:0]      grant;
  logic [31:0]        pkt_count;

  axis_pkt_arb #(.PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .fifo_full     (fifo_full),
    .grant         (grant),
    .pkt_count     (pkt_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [3:0]  en;
    logic        mr;
    logic        ff;
    logic [3:0]  e_grant;
    logic        e_mv;
    logic [31:0] e_data;
    logic        e_last;
    logic [31:0] e_pkt;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Source model: per-port beat/packet counters; beat word = {port, pkt, beat}.
  logic [3:0] src_en;
  int beat   [NP];
  int pkt_no [NP];
  int len    [NP];
  int maxp   [NP];

  logic [31:0] mon_q[$];
  int          mon_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < NP; i++) begin
      s_axis_tvalid[i]         = src_en[i] && (pkt_no[i] < maxp[i]);
      s_axis_tdata[i*DW +: DW] = {8'(i), 8'(pkt_no[i]), 16'(beat[i])};
      s_axis_tkeep[i*KW +: KW] = 4'(beat[i] + 1);
      s_axis_tlast[i]          = (beat[i] == len[i] - 1);
    end
  endtask

  task automatic src_reset(input int l, input int mp);
    for (int i = 0; i < NP; i++) begin
      beat[i] = 0; pkt_no[i] = 0; len[i] = l; maxp[i] = mp;
    end
    src_en = 4'b0000;
    drive_src();
  endtask

  task automatic set_en(input logic [3:0] v);
    src_en = v;
    drive_src();
  endtask

  // One clock: sample handshakes at negedge, advance sources just after posedge.
  task automatic cyc();
    logic [3:0] hs;
    logic       mhs;
    @(negedge aclk);
    hs  = s_axis_tvalid & s_axis_tready;
    mhs = m_axis_tvalid & m_axis_tready;
    if (mhs) begin
      mon_q.push_back(m_axis_tdata);
      mon_cyc.push_back(cyc_n);
    end
    @(posedge aclk);
    #1;
    cyc_n++;
    for (int i = 0; i < NP; i++) begin
      if (hs[i]) begin
        beat[i]++;
        if (beat[i] == len[i]) begin
          beat[i] = 0;
          pkt_no[i]++;
        end
      end
    end
    drive_src();
  endtask

  task automatic reset_dut();
    areset = 1'b1;
    cyc();
    cyc();
    areset = 1'b0;
  endtask

  vec_t tbl[12];

  initial begin
    logic [7:0]  exp_port[10];
    logic [31:0] w;

    tbl[0]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 32'h0,        1'b0, 32'd0};
    tbl[1]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 32'h02000000, 1'b0, 32'd0};
    tbl[2]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 32'h02000001, 1'b0, 32'd0};
    tbl[3]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 32'h02000002, 1'b1, 32'd0};
    tbl[4]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,        1'b0, 32'd1};
    tbl[5]  = '{4'b0010, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,        1'b0, 32'd1};
    tbl[6]  = '{4'b0010, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,        1'b0, 32'd1};
    tbl[7]  = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 32'h0,        1'b0, 32'd1};
    tbl[8]  = '{4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 32'h01000000, 1'b0, 32'd1};
    tbl[9]  = '{4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 32'h01000001, 1'b0, 32'd1};
    tbl[10] = '{4'b0010, 1'b1, 1'b1, 4'b0000, 1'b1, 32'h01000002, 1'b1, 32'd1};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,        1'b0, 32'd2};

    exp_port = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd0, 8'd0};

    areset        = 1'b1;
    m_axis_tready = 1'b1;
    fifo_full     = 1'b0;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = '0;
    src_reset(3, 1000);

    // Reset values
    reset_dut();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_mvalid", 32'(m_axis_tvalid), 32'h0);
    chk("rst_mdata", m_axis_tdata, 32'h0);
    chk("rst_pkt", pkt_count, 32'h0);
    chk("rst_sready", 32'(s_axis_tready), 32'h0);

    // Table: single packet on port 2, then fifo_full gating and mid-packet fifo_full
    for (int r = 0; r < 12; r++) begin
      m_axis_tready = tbl[r].mr;
      fifo_full     = tbl[r].ff;
      set_en(tbl[r].en);
      cyc();
      chk($sformatf("row%0d_grant", r), 32'(grant), 32'(tbl[r].e_grant));
      chk($sformatf("row%0d_mvalid", r), 32'(m_axis_tvalid), 32'(tbl[r].e_mv));
      chk($sformatf("row%0d_pkt", r), pkt_count, tbl[r].e_pkt);
      if (tbl[r].e_mv) begin
        chk($sformatf("row%0d_data", r), m_axis_tdata, tbl[r].e_data);
        chk($sformatf("row%0d_keep", r), 32'(m_axis_tkeep), 32'(4'(tbl[r].e_data[15:0] + 16'd1)));
        chk($sformatf("row%0d_last", r), 32'(m_axis_tlast), 32'(tbl[r].e_last));
      end
    end

    // All ports request at once with 2-beat packets: order 0,1,2,3,0 and one idle cycle between packets
    fifo_full = 1'b0;
    m_axis_tready = 1'b1;
    reset_dut();
    src_reset(2, 1000);
    mon_q.delete();
    mon_cyc.delete();
    set_en(4'b1111);
    for (int c = 0; c < 17; c++) cyc();
    chk("rr_beats_ge10", 32'(mon_q.size() >= 10), 32'd1);
    for (int k = 0; k < 10 && k < mon_q.size(); k++) begin
      w = mon_q[k];
      chk($sformatf("rr_port%0d", k), 32'(w[31:24]), 32'(exp_port[k]));
      chk($sformatf("rr_beat%0d", k), 32'(w[15:0]), 32'(k % 2));
      chk($sformatf("rr_pktno%0d", k), 32'(w[23:16]), (k >= 8) ? 32'd1 : 32'd0);
      if (k > 0)
        chk($sformatf("rr_gap%0d", k), 32'(mon_cyc[k] - mon_cyc[k-1]), (k % 2 == 0) ? 32'd2 : 32'd1);
    end

    // Backpressure for 5 cycles mid-packet on port 3
    reset_dut();
    src_reset(4, 1);
    mon_q.delete();
    mon_cyc.delete();
    set_en(4'b1000);
    cyc();
    chk("bp_grant", 32'(grant), 32'h8);
    cyc();
    m_axis_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk($sformatf("bp_hold_data%0d", c), m_axis_tdata, 32'h03000000);
      chk($sformatf("bp_hold_valid%0d", c), 32'(m_axis_tvalid), 32'd1);
      chk($sformatf("bp_sready%0d", c), 32'(s_axis_tready), 32'h0);
    end
    m_axis_tready = 1'b1;
    for (int c = 0; c < 8; c++) cyc();
    chk("bp_count", 32'(mon_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < mon_q.size(); k++)
      chk($sformatf("bp_beat%0d", k), mon_q[k], {8'd3, 8'd0, 16'(k)});
    chk("bp_pkt", pkt_count, 32'd1);

    // Reset on beat 2 of 4 truncates the packet; port 0 wins afterwards
    src_reset(4, 1000);
    set_en(4'b0010);
    cyc();
    chk("mr_grant", 32'(grant), 32'h2);
    cyc();
    cyc();
    chk("mr_beat2", m_axis_tdata, 32'h01000001);
    areset = 1'b1;
    cyc();
    chk("mr_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("mr_grant0", 32'(grant), 32'h0);
    chk("mr_pkt", pkt_count, 32'd0);
    areset = 1'b0;
    set_en(4'b0011);
    cyc();
    chk("mr_regrant", 32'(grant), 32'h1);

    // pkt_count wrap from all-ones
    reset_dut();
    src_reset(1, 1);
    force dut.pkt_count = 32'hFFFF_FFFF;
    cyc();
    release dut.pkt_count;
    cyc();
    chk("wrap_preload", pkt_count, 32'hFFFF_FFFF);
    set_en(4'b0100);
    for (int c = 0; c < 4; c++) cyc();
    chk("wrap_zero", pkt_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
